// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver for a packed BCD value, with leading-zero blanking and invalid-digit flag.
// Optional anti-ghosting gap at the start of each digit slot: define BCD_SCAN_GHOST_BLANK_EN.
module bcd_display_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  bad
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic                tc;
  logic [3:0]          digit;
  logic [DIGITS-1:0]   lz;
  logic                zero_run;
  logic                bad_nxt;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    tc       = (pre == PW'(SCAN_DIV - 1));
    digit    = shadow[4*idx +: 4];
    bad_nxt  = 1'b0;
    lz       = '0;
    zero_run = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      bad_nxt = bad_nxt | (bcd_in[4*i +: 4] > 4'd9);
    end
    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow[4*i +: 4] == 4'd0);
      lz[i]    = zero_run & (i != 0);
    end
    an_nxt      = '0;
    an_nxt[idx] = 1'b1;
    seg_nxt     = (blank_lz && lz[idx]) ? 7'h00 : decode(digit);
`ifdef BCD_SCAN_GHOST_BLANK_EN
    if (pre == '0) begin
      an_nxt  = '0;
      seg_nxt = 7'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      pre    <= '0;
      idx    <= '0;
      seg    <= 7'h00;
      an     <= '0;
      bad    <= 1'b0;
    end else begin
      pre <= tc ? '0 : pre + 1'b1;
      if (tc) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (load) begin
        shadow <= bcd_in;
        bad    <= bad_nxt;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
